// File: rtl/gyruss_pkg.sv
// Shared constants and types for the Gyruss ROM download path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gyruss_pkg;

    // Region bases inside the downloaded ROM image
    localparam logic [16:0] BG_CHR_BASE = 17'h08000;
    localparam logic [16:0] CLUT_BASE   = 17'h17100;
    localparam logic [16:0] PAL_BASE    = 17'h17200;
    // First address past the end of the image
    localparam logic [16:0] ROM_SIZE    = 17'h17300;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One queued ROM write
    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    // Compare the full download address so high-order bits can never alias into the ROM
    function automatic logic addr_in_range(input logic [24:0] addr, input logic [16:0] limit);
        return addr < {8'd0, limit};
    endfunction

endpackage

// File: rtl/gyruss_dl_fifo.sv
// Small synchronous FIFO holding pending ROM writes.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module gyruss_dl_fifo #(
    parameter int AW = 2,
    parameter int W  = 25
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally; occupancy tracked separately to tell full from empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/gyruss_rom_loader.sv
// Drives the ROMCL/ROMAD/ROMID/ROMEN download bus from the HPS byte stream.
// Latency: 2 MCLK from an accepted byte to its ROMEN pulse when the FIFO is empty.
// Backpressure: DL_WAIT high means the byte on DL_WR is not taken and must be held.
module gyruss_rom_loader #(
    parameter int          FIFO_AW  = 2,
    parameter logic [16:0] ROM_SIZE = gyruss_pkg::ROM_SIZE,
    parameter int          GAP      = 1,
    parameter logic [7:0]  DL_IDX   = 8'h00
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        DL_DOWNLOAD,
    input  logic [7:0]  DL_INDEX,
    input  logic        DL_WR,
    input  logic [24:0] DL_ADDR,
    input  logic [7:0]  DL_DATA,
    output logic        DL_WAIT,
    output logic        ROMCL,
    output logic [16:0] ROMAD,
    output logic [7:0]  ROMID,
    output logic        ROMEN,
    output logic        LOADED,
    output logic        OVERRUN,
    output logic [16:0] BCNT
);
    import gyruss_pkg::*;

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [2:0]       GAP_LD   = 3'(GAP);

    state_e           state_q;
    logic             dl_q;
    logic [2:0]       gap_q, gap_d;
    logic             wait_q, wait_d;
    logic             romen_q;
    logic [16:0]      romad_q;
    logic [7:0]       romid_q;
    logic             loaded_q;
    logic             overrun_q;
    logic [16:0]      bcnt_q;

    dl_entry_t        push_ent;
    dl_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_cnt;
    logic [FIFO_AW:0] cnt_d;

    logic             active;
    logic             start;
    logic             in_rng;
    logic             push;
    logic             drop;
    logic             pop;
    logic             pop_nxt;

    assign push_ent = '{addr: DL_ADDR[16:0], data: DL_DATA};

    gyruss_dl_fifo #(
        .AW (FIFO_AW),
        .W  ($bits(dl_entry_t))
    ) u_fifo (
        .clk_i   (MCLK),
        .rst_i   (RESET),
        .push_i  (push),
        .wdata_i (push_ent),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Accept/drop/pop decisions and the look-ahead used to register DL_WAIT
    always_comb begin
        active  = (state_q == LOAD) || (state_q == DRAIN);
        start   = DL_DOWNLOAD && !dl_q && (DL_INDEX == DL_IDX) &&
                  ((state_q == IDLE) || (state_q == DONE));
        in_rng  = addr_in_range(DL_ADDR, ROM_SIZE);
        pop     = !fifo_empty && (gap_q == 3'd0);
        push    = active && DL_WR && !wait_q && in_rng && (!fifo_full || pop);
        drop    = active && DL_WR && !in_rng;

        gap_d = gap_q;
        if (start) begin
            gap_d = 3'd0;
        end else if (pop) begin
            gap_d = GAP_LD;
        end else if (gap_q != 3'd0) begin
            gap_d = gap_q - 3'd1;
        end

        cnt_d = fifo_cnt;
        case ({push, pop})
            2'b10:   cnt_d = fifo_cnt + 1'b1;
            2'b01:   cnt_d = fifo_cnt - 1'b1;
            default: cnt_d = fifo_cnt;
        endcase

        // Wait next cycle only if the FIFO will be full and nothing will leave it,
        // so DL_WAIT low always means the presented byte is taken
        pop_nxt = (cnt_d != '0) && (gap_d == 3'd0);
        wait_d  = (cnt_d == FULL_CNT) && !pop_nxt;
    end

    // Session FSM plus all registered bus and status outputs
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            dl_q      <= 1'b0;
            gap_q     <= 3'd0;
            wait_q    <= 1'b0;
            romen_q   <= 1'b0;
            romad_q   <= 17'd0;
            romid_q   <= 8'd0;
            loaded_q  <= 1'b0;
            overrun_q <= 1'b0;
            bcnt_q    <= 17'd0;
        end else begin
            dl_q    <= DL_DOWNLOAD;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            romen_q <= pop;
            if (pop) begin
                romad_q <= head.addr;
                romid_q <= head.data;
                bcnt_q  <= bcnt_q + 17'd1;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        loaded_q  <= 1'b0;
                        overrun_q <= 1'b0;
                        bcnt_q    <= 17'd0;
                    end
                end
                LOAD: begin
                    if (!DL_DOWNLOAD) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last pop already issued and nothing arriving: done as its pulse ends
                    if (fifo_empty && !push) begin
                        state_q  <= DONE;
                        loaded_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ROMCL   = MCLK;
    assign ROMAD   = romad_q;
    assign ROMID   = romid_q;
    assign ROMEN   = romen_q;
    assign DL_WAIT = wait_q;
    assign LOADED  = loaded_q;
    assign OVERRUN = overrun_q;
    assign BCNT    = bcnt_q;

endmodule
